vp8_txfm4x4_pipe: RTL and testbench
===================================

Name: vp8_txfm4x4_pipe

Overview:
- Streaming 4x4 VP8 transform engine for the encoder residual path.
- Forward mode (FWD) computes the integer DCT of src-ref.
- Inverse mode (INV) reconstructs clip8(ref + IDCT(coef)).
- Two-stage pipeline with valid/ready on both sides, throughput 1 block/cycle, per-block mode and tag carried alongside the data.

Parameters:
- COEF_W, 12, width of each signed coefficient lane on coef_in and out_data; legal range 12..16.
- TAG_W, 4, width of the opaque sideband tag passed through with each block.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  block accepted on in_valid&&in_ready.
- in_mode  in  1  0=FWD, 1=INV.
- in_tag  in  TAG_W  sideband, returned unchanged on out_tag.
- src  in  128  16 x 8b unsigned pixels; lane k=4*row+col at bits [8k+7:8k]; used in FWD only.
- ref  in  128  16 x 8b unsigned prediction, same packing; used in both modes.
- coef_in  in  16*COEF_W  16 signed coefficients, lane k at [COEF_W*k+COEF_W-1 : COEF_W*k]; used in INV only.
- out_valid  out  1  output block valid.
- out_ready  in  1  downstream accepts on out_valid&&out_ready.
- out_mode  out  1  mode of the output block.
- out_tag  out  TAG_W  tag of the output block.
- out_data  out  16*COEF_W  FWD: signed coefficients; INV: pixels 0..255 zero-extended; same packing as coef_in.
- busy  out  1  any pipeline stage holds a valid block.

Behaviour:
- Reset: in_ready=1, out_valid=0, busy=0. out_data, out_mode, out_tag and all stage registers are 0.
- Pipeline control: stage valids v1, v2; en2 = !v2 | out_ready; en1 = !v1 | en2; in_ready = en1 (combinational from out_ready, no path from in_valid).
- Latency: block accepted at edge N appears with out_valid=1 after edge N+1, i.e. 2 cycles, when unstalled.
- Back-to-back accepts with out_ready=1 give one output per cycle, no bubbles.
- Stall: while out_valid && !out_ready, out_data, out_mode and out_tag hold stable. Stage 1 keeps its block when v2 is stalled. Upstream sees in_ready=0 only when both stages are full.
- Data, mode and tag registers load only on a valid transfer into their stage, and hold otherwise.
- busy = v1 | v2.
- FWD stage 1, per row r, with d_c = src[4r+c] - ref[4r+c] (9b signed):
  - a0 = d0+d3, a1 = d1+d2, a2 = d1-d2, a3 = d0-d3.
  - t[4r+0] = (a0+a1)*8.
  - t[4r+1] = (a2*2217 + a3*5352 + 1812) >>> 9.
  - t[4r+2] = (a0-a1)*8.
  - t[4r+3] = (a3*2217 - a2*5352 + 937) >>> 9.
- FWD stage 2, per column c:
  - b0 = t[c]+t[c+12], b1 = t[c+4]+t[c+8], b2 = t[c+4]-t[c+8], b3 = t[c]-t[c+12].
  - out[c] = (b0+b1+7) >>> 4.
  - out[c+4] = ((b2*2217 + b3*5352 + 12000) >>> 16) + (b3 != 0).
  - out[c+8] = (b0-b1+7) >>> 4.
  - out[c+12] = (b3*2217 - b2*5352 + 51000) >>> 16.
- INV definitions: M1(x) = ((x*20091) >>> 16) + x; M2(x) = (x*35468) >>> 16.
- INV stage 1, per column c, with i_k = coef[c+4k]:
  - a = i0+i2, b = i0-i2, cc = M2(i1) - M1(i3), d = M1(i1) + M2(i3).
  - t[4c+0] = a+d, t[4c+1] = b+cc, t[4c+2] = b-cc, t[4c+3] = a-d.
- INV stage 2, per row r:
  - dc = t[r]+4, a = dc+t[r+8], b = dc-t[r+8].
  - cc = M2(t[r+4]) - M1(t[r+12]), d = M1(t[r+4]) + M2(t[r+12]).
  - Row values v0..v3 = a+d, b+cc, b-cc, a-d.
  - out[4r+k] = clip(ref[4r+k] + (v_k >>> 3), 0, 255).
- ref is needed in stage 2 for INV, so it is registered in stage 1.
- Arithmetic: all internal math is signed and full-precision, with at least 20b products and 18b intermediate registers. >>> is floor. No saturation except the INV clip.
- FWD results fit 12b and are sign-extended to COEF_W.
- Mixed modes may be interleaved cycle to cycle; each block uses its own registered mode in stage 2.
- Reset mid-operation: in-flight blocks are discarded, not delivered; on release the outputs restart clean with out_valid=0.

Decomposition:
- Package vp8_txfm_pkg holds:
  - constants K2217, K5352, K20091, K35468, FWD_RND1=1812, FWD_RND3=937, FWD_RND_C2=12000, FWD_RND_C3=51000;
  - mode enum FWD/INV;
  - the M1/M2 functions.
- One sub-module, vp8_txfm_butterfly4: a combinational 4-point butterfly selected by mode and pass, instantiated 4x per stage.

Test Plan:
- FWD: src all 10, ref all 0 -> out[0]=80, out[1]=1, all other lanes 0, out_valid 2 cycles after accept.
- INV: coef[0]=8, others 0, ref all 100 -> all 16 pixels 101.
- INV clip:
  - coef[0]=400, ref all 250 -> all 255.
  - coef[0]=-400, ref all 5 -> all 0, since -396 >>> 3 = -50.
- Streaming: 8 blocks back-to-back with alternating mode and tag 0..7, out_ready=1 -> 8 consecutive out_valid cycles, tags in order, each result matches the C model.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready drops after 2 accepts and out_data stays stable.
  - Release out_ready -> no loss or duplication of blocks.
- Reset: assert rst_n=0 with both stages full -> out_valid=0, busy=0 and out_data=0 immediately; after release the first output is the next accepted block.

Source files
------------

// File: rtl/vp8_txfm_pkg.sv
// rtl/vp8_txfm_pkg.sv - shared constants, types and helpers for the VP8 4x4 transform pipe
package vp8_txfm_pkg;

  localparam int ACC_W = 40;
  localparam int T_W   = 18;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [T_W-1:0]   stage_t;

  typedef enum logic {
    FWD = 1'b0,
    INV = 1'b1
  } txfm_mode_e;

  localparam acc_t K2217      = acc_t'(2217);
  localparam acc_t K5352      = acc_t'(5352);
  localparam acc_t K20091     = acc_t'(20091);
  localparam acc_t K35468     = acc_t'(35468);
  localparam acc_t FWD_RND1   = acc_t'(1812);
  localparam acc_t FWD_RND3   = acc_t'(937);
  localparam acc_t FWD_RND_C2 = acc_t'(12000);
  localparam acc_t FWD_RND_C3 = acc_t'(51000);

  // Products of an 18b stage value with the 16b constants need more than 32 bits.
  function automatic acc_t m1(input acc_t x);
    return ((x * K20091) >>> 16) + x;
  endfunction

  function automatic acc_t m2(input acc_t x);
    return (x * K35468) >>> 16;
  endfunction

  function automatic logic [7:0] clip8(input acc_t x);
    logic [7:0] r;
    if (x < acc_t'(0))
      r = 8'd0;
    else if (x > acc_t'(255))
      r = 8'd255;
    else
      r = x[7:0];
    return r;
  endfunction

endpackage

// File: rtl/vp8_txfm_butterfly4.sv
// rtl/vp8_txfm_butterfly4.sv - combinational 4-point VP8 butterfly for both modes and both passes
module vp8_txfm_butterfly4
  import vp8_txfm_pkg::*;
(
  input  txfm_mode_e mode_i,
  input  logic       pass_i,
  input  acc_t       x0_i,
  input  acc_t       x1_i,
  input  acc_t       x2_i,
  input  acc_t       x3_i,
  output acc_t       y0_o,
  output acc_t       y1_o,
  output acc_t       y2_o,
  output acc_t       y3_o
);

  acc_t sum03, sum12, dif12, dif03;
  acc_t rot_p, rot_n;
  acc_t dc, ia, ib, ic, id;

  always_comb begin
    sum03 = x0_i + x3_i;
    sum12 = x1_i + x2_i;
    dif12 = x1_i - x2_i;
    dif03 = x0_i - x3_i;
    rot_p = dif12 * K2217 + dif03 * K5352;
    rot_n = dif03 * K2217 - dif12 * K5352;

    // The inverse row pass folds its +4 rounding into the DC term.
    dc = pass_i ? x0_i + acc_t'(4) : x0_i;
    ia = dc + x2_i;
    ib = dc - x2_i;
    ic = m2(x1_i) - m1(x3_i);
    id = m1(x1_i) + m2(x3_i);

    y0_o = '0;
    y1_o = '0;
    y2_o = '0;
    y3_o = '0;
    if (mode_i == FWD) begin
      if (!pass_i) begin
        y0_o = (sum03 + sum12) <<< 3;
        y1_o = (rot_p + FWD_RND1) >>> 9;
        y2_o = (sum03 - sum12) <<< 3;
        y3_o = (rot_n + FWD_RND3) >>> 9;
      end else begin
        y0_o = (sum03 + sum12 + acc_t'(7)) >>> 4;
        y1_o = ((rot_p + FWD_RND_C2) >>> 16) + ((dif03 != '0) ? acc_t'(1) : acc_t'(0));
        y2_o = (sum03 - sum12 + acc_t'(7)) >>> 4;
        y3_o = (rot_n + FWD_RND_C3) >>> 16;
      end
    end else begin
      if (!pass_i) begin
        y0_o = ia + id;
        y1_o = ib + ic;
        y2_o = ib - ic;
        y3_o = ia - id;
      end else begin
        y0_o = (ia + id) >>> 3;
        y1_o = (ib + ic) >>> 3;
        y2_o = (ib - ic) >>> 3;
        y3_o = (ia - id) >>> 3;
      end
    end
  end

endmodule

// File: rtl/vp8_txfm4x4_pipe.sv
// rtl/vp8_txfm4x4_pipe.sv - two-stage streaming 4x4 VP8 forward/inverse transform
module vp8_txfm4x4_pipe
  import vp8_txfm_pkg::*;
#(
  parameter int COEF_W = 12,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [127:0]         src,
  input  logic [127:0]         ref_pix,
  input  logic [16*COEF_W-1:0] coef_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_mode,
  output logic [TAG_W-1:0]     out_tag,
  output logic [16*COEF_W-1:0] out_data,
  output logic                 busy
);

  logic                 v1_q, v2_q;
  logic                 en1, en2, acc1, ld2;
  txfm_mode_e           s1_mode_d, s1_mode_q, out_mode_q;
  logic [TAG_W-1:0]     s1_tag_q, out_tag_q;
  logic [127:0]         s1_ref_q;
  stage_t               s1_t_d [16];
  stage_t               s1_t_q [16];
  logic [16*COEF_W-1:0] out_data_d, out_data_q;

  acc_t s1_x [4][4];
  acc_t s1_y [4][4];
  acc_t s2_x [4][4];
  acc_t s2_y [4][4];

  // A stage may advance when the stage after it is empty or draining.
  assign en2       = !v2_q || out_ready;
  assign en1       = !v1_q || en2;
  assign acc1      = in_valid && en1;
  assign ld2       = v1_q && en2;
  assign s1_mode_d = txfm_mode_e'(in_mode);

  // Butterfly j sees row j (FWD) or column j (INV) and writes t[4j+k] either way.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) begin
        if (s1_mode_d == FWD)
          s1_x[j][k] = acc_t'(src[8*(4*j+k) +: 8]) - acc_t'(ref_pix[8*(4*j+k) +: 8]);
        else
          s1_x[j][k] = acc_t'($signed(coef_in[COEF_W*(j+4*k) +: COEF_W]));
        s1_t_d[4*j+k] = stage_t'(s1_y[j][k]);
        s2_x[j][k]    = acc_t'(s1_t_q[j+4*k]);
      end
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_bfly
    vp8_txfm_butterfly4 u_stage1 (
      .mode_i (s1_mode_d),
      .pass_i (1'b0),
      .x0_i   (s1_x[j][0]),
      .x1_i   (s1_x[j][1]),
      .x2_i   (s1_x[j][2]),
      .x3_i   (s1_x[j][3]),
      .y0_o   (s1_y[j][0]),
      .y1_o   (s1_y[j][1]),
      .y2_o   (s1_y[j][2]),
      .y3_o   (s1_y[j][3])
    );

    vp8_txfm_butterfly4 u_stage2 (
      .mode_i (s1_mode_q),
      .pass_i (1'b1),
      .x0_i   (s2_x[j][0]),
      .x1_i   (s2_x[j][1]),
      .x2_i   (s2_x[j][2]),
      .x3_i   (s2_x[j][3]),
      .y0_o   (s2_y[j][0]),
      .y1_o   (s2_y[j][1]),
      .y2_o   (s2_y[j][2]),
      .y3_o   (s2_y[j][3])
    );
  end

  // FWD second pass is per column, INV second pass is per row: the output lane map transposes.
  always_comb begin
    out_data_d = '0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) begin
        if (s1_mode_q == FWD)
          out_data_d[COEF_W*(j+4*k) +: COEF_W] = COEF_W'(s2_y[j][k]);
        else
          out_data_d[COEF_W*(4*j+k) +: COEF_W] =
            COEF_W'(clip8(acc_t'(s1_ref_q[8*(4*j+k) +: 8]) + s2_y[j][k]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      if (en1) v1_q <= in_valid;
      if (en2) v2_q <= v1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mode_q <= FWD;
      s1_tag_q  <= '0;
      s1_ref_q  <= '0;
      for (int i = 0; i < 16; i++) s1_t_q[i] <= '0;
    end else if (acc1) begin
      s1_mode_q <= s1_mode_d;
      s1_tag_q  <= in_tag;
      s1_ref_q  <= ref_pix;
      s1_t_q    <= s1_t_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_mode_q <= FWD;
      out_tag_q  <= '0;
      out_data_q <= '0;
    end else if (ld2) begin
      out_mode_q <= s1_mode_q;
      out_tag_q  <= s1_tag_q;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = en1;
  assign out_valid = v2_q;
  assign out_mode  = out_mode_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;
  assign busy      = v1_q | v2_q;

endmodule

// File: tb/tb_vp8_txfm4x4_pipe.sv
// tb/tb_vp8_txfm4x4_pipe.sv - self-checking bench with a behavioural 4x4 transform model
module tb_vp8_txfm4x4_pipe;

  localparam int COEF_W = 12;
  localparam int TAG_W  = 4;
  localparam int OW     = 16 * COEF_W;
  localparam int BW     = OW + TAG_W + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid, in_ready, in_mode;
  logic [TAG_W-1:0]     in_tag;
  logic [127:0]         src, ref_pix;
  logic [OW-1:0]        coef_in;
  logic                 out_valid, out_ready, out_mode, busy;
  logic [TAG_W-1:0]     out_tag;
  logic [OW-1:0]        out_data;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_out    = 0;
  logic [BW-1:0] exp_q [$];
  logic          stall_prev = 1'b0;
  logic [BW-1:0] stall_val;
  logic          rand_done;

  vp8_txfm4x4_pipe #(.COEF_W(COEF_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .src       (src),
    .ref_pix   (ref_pix),
    .coef_in   (coef_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_tag   (out_tag),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint pix(input logic [127:0] v, input int k);
    return longint'(v[8*k +: 8]);
  endfunction

  function automatic longint cf(input logic [OW-1:0] v, input int k);
    return longint'($signed(v[COEF_W*k +: COEF_W]));
  endfunction

  function automatic longint mm1(input longint x);
    return ((x * 20091) >>> 16) + x;
  endfunction

  function automatic longint mm2(input longint x);
    return (x * 35468) >>> 16;
  endfunction

  function automatic longint clamp(input longint x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  // Whole-block reference: residual DCT or clipped reconstruction, straight from the transform equations.
  function automatic logic [OW-1:0] model(input logic m, input logic [127:0] s, input logic [127:0] r,
                                          input logic [OW-1:0] c);
    longint t [16];
    longint o [16];
    longint e0, e1, e2, e3, p, q, u, w;
    logic [OW-1:0] res;
    if (m == 1'b0) begin
      for (int rr = 0; rr < 4; rr++) begin
        e0 = pix(s, 4*rr)   - pix(r, 4*rr);
        e1 = pix(s, 4*rr+1) - pix(r, 4*rr+1);
        e2 = pix(s, 4*rr+2) - pix(r, 4*rr+2);
        e3 = pix(s, 4*rr+3) - pix(r, 4*rr+3);
        p = e0 + e3; q = e1 + e2; u = e1 - e2; w = e0 - e3;
        t[4*rr]   = (p + q) * 8;
        t[4*rr+1] = (u * 2217 + w * 5352 + 1812) >>> 9;
        t[4*rr+2] = (p - q) * 8;
        t[4*rr+3] = (w * 2217 - u * 5352 + 937) >>> 9;
      end
      for (int cc = 0; cc < 4; cc++) begin
        p = t[cc] + t[cc+12]; q = t[cc+4] + t[cc+8];
        u = t[cc+4] - t[cc+8]; w = t[cc] - t[cc+12];
        o[cc]    = (p + q + 7) >>> 4;
        o[cc+4]  = ((u * 2217 + w * 5352 + 12000) >>> 16) + ((w != 0) ? 1 : 0);
        o[cc+8]  = (p - q + 7) >>> 4;
        o[cc+12] = (w * 2217 - u * 5352 + 51000) >>> 16;
      end
    end else begin
      for (int cc = 0; cc < 4; cc++) begin
        p = cf(c, cc) + cf(c, cc+8);
        q = cf(c, cc) - cf(c, cc+8);
        u = mm2(cf(c, cc+4)) - mm1(cf(c, cc+12));
        w = mm1(cf(c, cc+4)) + mm2(cf(c, cc+12));
        t[4*cc]   = p + w;
        t[4*cc+1] = q + u;
        t[4*cc+2] = q - u;
        t[4*cc+3] = p - w;
      end
      for (int rr = 0; rr < 4; rr++) begin
        e0 = t[rr] + 4;
        p = e0 + t[rr+8]; q = e0 - t[rr+8];
        u = mm2(t[rr+4]) - mm1(t[rr+12]);
        w = mm1(t[rr+4]) + mm2(t[rr+12]);
        o[4*rr]   = clamp(pix(r, 4*rr)   + ((p + w) >>> 3));
        o[4*rr+1] = clamp(pix(r, 4*rr+1) + ((q + u) >>> 3));
        o[4*rr+2] = clamp(pix(r, 4*rr+2) + ((q - u) >>> 3));
        o[4*rr+3] = clamp(pix(r, 4*rr+3) + ((p - w) >>> 3));
      end
    end
    for (int k = 0; k < 16; k++) res[COEF_W*k +: COEF_W] = o[k][COEF_W-1:0];
    return res;
  endfunction

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (in_valid && in_ready)
        exp_q.push_back({in_mode, in_tag, model(in_mode, src, ref_pix, coef_in)});
      if (stall_prev && out_valid)
        check("stall_hold", {out_mode, out_tag, out_data}, stall_val);
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_mode, out_tag, out_data};
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else check("sb_block", {out_mode, out_tag, out_data}, exp_q.pop_front());
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic m, input logic [TAG_W-1:0] tg, input logic [127:0] s,
                      input logic [127:0] r, input logic [OW-1:0] c);
    in_valid = 1'b1;
    in_mode  = m;
    in_tag   = tg;
    src      = s;
    ref_pix  = r;
    coef_in  = c;
    wait_accept();
    in_valid = 1'b0;
  endtask

  task automatic drive_rand(input logic m, input logic [TAG_W-1:0] tg);
    logic [OW-1:0] c = '0;
    for (int i = 0; i < (OW + 31) / 32; i++) c = (c << 32) | OW'($urandom);
    in_mode = m;
    in_tag  = tg;
    src     = {$urandom, $urandom, $urandom, $urandom};
    ref_pix = {$urandom, $urandom, $urandom, $urandom};
    coef_in = c;
  endtask

  task automatic send_rand(input logic m, input logic [TAG_W-1:0] tg);
    drive_rand(m, tg);
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check(tag, out_valid, 1);
  endtask

  task automatic expect_next(input string tag, input logic [OW-1:0] e);
    wait_valid({tag, "_timeout"});
    check(tag, out_data, e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_busy", busy, 0);
    #1;
    check("sb_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OW-1:0]  e;
    logic [OW-1:0]  held;
    logic [127:0]   r;
    int             acc, n0;

    in_valid = 1'b0; in_mode = 1'b0; in_tag = '0;
    src = '0; ref_pix = '0; coef_in = '0; out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_outputs", {out_mode, out_tag, out_data}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // FWD flat residual, with exact latency
    send(1'b0, 4'h1, {16{8'd10}}, '0, '0);
    @(negedge clk);
    check("fwd_lat_early", out_valid, 0);
    @(negedge clk);
    check("fwd_lat", out_valid, 1);
    e = '0;
    e[0 +: COEF_W]      = COEF_W'(80);
    e[COEF_W +: COEF_W] = COEF_W'(1);
    check("fwd_flat", out_data, e);
    @(posedge clk);
    #1;

    // INV DC-only reconstructions, including both clip rails
    e = '0; e[0 +: COEF_W] = COEF_W'(8);
    send(1'b1, 4'h2, '0, {16{8'd100}}, e);
    for (int k = 0; k < 16; k++) e[COEF_W*k +: COEF_W] = COEF_W'(101);
    expect_next("inv_dc", e);

    e = '0; e[0 +: COEF_W] = COEF_W'(400);
    send(1'b1, 4'h3, '0, {16{8'd250}}, e);
    for (int k = 0; k < 16; k++) e[COEF_W*k +: COEF_W] = COEF_W'(255);
    expect_next("inv_clip_hi", e);

    e = '0; e[0 +: COEF_W] = COEF_W'(-400);
    send(1'b1, 4'h4, '0, {16{8'd5}}, e);
    expect_next("inv_clip_lo", '0);
    drain();

    // Back-to-back stream, alternating modes
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(i[0], TAG_W'(i));
      end
      begin
        wait_valid("stream_start");
        for (int i = 0; i < 8; i++) begin
          check("stream_valid", out_valid, 1);
          check("stream_tag", out_tag, TAG_W'(i));
          @(negedge clk);
        end
      end
    join
    drain();

    // Backpressure with a continuously offered input
    n0 = n_out;
    acc = 0;
    out_ready = 1'b0;
    drive_rand(1'b1, 4'h5);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 2) check("bp_in_ready", in_ready, 0);
      if (i == 2) held = out_data;
      if (i == 4) check("bp_out_hold", out_data, held);
      if (in_ready) begin
        acc++;
        @(posedge clk);
        #1 drive_rand(acc[0], TAG_W'(5 + acc));
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check("bp_accepts", acc, 2);
    check("bp_busy", busy, 1);
    out_ready = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    drain();
    check("bp_out_count", n_out - n0, 3);

    // Reset with both stages full
    out_ready = 1'b0;
    send_rand(1'b0, 4'h8);
    send_rand(1'b1, 4'h9);
    @(negedge clk);
    check("full_state", {out_valid, busy, in_ready}, 3'b110);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_data", out_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_idle", out_valid, 0);
    @(posedge clk);
    #1;
    r = {$urandom, $urandom, $urandom, $urandom};
    send(1'b0, 4'hA, {$urandom, $urandom, $urandom, $urandom}, r, '0);
    wait_valid("post_rst_timeout");
    check("post_rst_tag", out_tag, 4'hA);
    @(posedge clk);
    #1;
    drain();

    // Randomized traffic with random gaps and random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          int g;
          send_rand(1'($urandom), TAG_W'($urandom));
          g = $urandom_range(0, 2);
          if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
